// File: rtl/vc_read_scheduler.sv
// Read-slot scheduler for one router input port: picks one eligible VC buffer per
// cycle in flit-level round-robin order and tracks each VC's packet framing.
package vc_read_scheduler_pkg;
    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;
endpackage

// state  | meaning
// IDLE   | between packets; HEAD or HEADTAIL expected next
// ACTIVE | head read, tail not yet read; BODY or TAIL expected next
module vc_read_scheduler
    import vc_read_scheduler_pkg::*;
#(
    parameter  int VC_NUM  = 2,
    localparam int VC_SIZE = $clog2(VC_NUM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [VC_NUM-1:0]  is_empty_i,
    input  logic [VC_NUM-1:0]  on_off_i,
    input  flit_label_t        flit_label_i [VC_NUM],
    input  logic               stall_i,
    output logic [VC_NUM-1:0]  read_o,
    output logic               valid_o,
    output logic [VC_SIZE-1:0] vc_sel_o,
    output logic [VC_NUM-1:0]  packet_active_o,
    output logic               protocol_err_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } vc_state_t;

    logic [VC_NUM-1:0]  elig;
    logic [VC_SIZE-1:0] rr_ptr;
    logic [VC_SIZE:0]   scan;
    vc_state_t          state_q [VC_NUM];
    vc_state_t          state_d [VC_NUM];
    logic               err_q;
    logic               err_set;

    // Grant is also gated by rst so nothing is read while the port is held in reset.
    assign elig = ~is_empty_i & on_off_i & {VC_NUM{~stall_i & rst}};

    // Scan one extra bit wide so the modulo wrap works for non-power-of-2 VC_NUM.
    always_comb begin
        read_o   = '0;
        valid_o  = 1'b0;
        vc_sel_o = '0;
        scan     = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            scan = {1'b0, rr_ptr} + (VC_SIZE+1)'(i);
            if (scan >= (VC_SIZE+1)'(VC_NUM)) begin
                scan = scan - (VC_SIZE+1)'(VC_NUM);
            end
            if (!valid_o && elig[scan[VC_SIZE-1:0]]) begin
                valid_o  = 1'b1;
                vc_sel_o = scan[VC_SIZE-1:0];
            end
        end
        if (valid_o) begin
            read_o[vc_sel_o] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        if (valid_o) begin
            case (state_q[vc_sel_o])
                IDLE: begin
                    case (flit_label_i[vc_sel_o])
                        HEAD:     state_d[vc_sel_o] = ACTIVE;
                        HEADTAIL: state_d[vc_sel_o] = IDLE;
                        default:  err_set = 1'b1;
                    endcase
                end
                ACTIVE: begin
                    case (flit_label_i[vc_sel_o])
                        BODY: state_d[vc_sel_o] = ACTIVE;
                        TAIL: state_d[vc_sel_o] = IDLE;
                        HEAD: err_set = 1'b1;
                        default: begin
                            state_d[vc_sel_o] = IDLE;
                            err_set           = 1'b1;
                        end
                    endcase
                end
                default: err_set = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
            err_q  <= 1'b0;
            for (int v = 0; v < VC_NUM; v++) begin
                state_q[v] <= IDLE;
            end
        end else begin
            if (valid_o) begin
                rr_ptr <= (vc_sel_o == VC_SIZE'(VC_NUM-1)) ? '0 : vc_sel_o + 1'b1;
            end
            for (int v = 0; v < VC_NUM; v++) begin
                state_q[v] <= state_d[v];
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        packet_active_o = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            packet_active_o[v] = (state_q[v] == ACTIVE);
        end
    end

    assign protocol_err_o = err_q;

endmodule

// File: tb/tb_vc_read_scheduler.sv
// Directed bench for vc_read_scheduler: a vector table on a 2-VC instance plus
// hand sequences for async reset mid-packet and 3-VC wrap-around.
module tb_vc_read_scheduler;
    import vc_read_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  is_empty, on_off;
    flit_label_t lab [2];
    logic        stall;
    logic [1:0]  read;
    logic        valid;
    logic [0:0]  vc_sel;
    logic [1:0]  active;
    logic        err;

    logic [2:0]  is_empty3, on_off3;
    flit_label_t lab3 [3];
    logic        stall3;
    logic [2:0]  read3;
    logic        valid3;
    logic [1:0]  vc_sel3;
    logic [2:0]  active3;
    logic        err3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vc_read_scheduler #(.VC_NUM(2)) dut (
        .clk(clk), .rst(rst), .is_empty_i(is_empty), .on_off_i(on_off),
        .flit_label_i(lab), .stall_i(stall), .read_o(read), .valid_o(valid),
        .vc_sel_o(vc_sel), .packet_active_o(active), .protocol_err_o(err)
    );

    vc_read_scheduler #(.VC_NUM(3)) dut3 (
        .clk(clk), .rst(rst), .is_empty_i(is_empty3), .on_off_i(on_off3),
        .flit_label_i(lab3), .stall_i(stall3), .read_o(read3), .valid_o(valid3),
        .vc_sel_o(vc_sel3), .packet_active_o(active3), .protocol_err_o(err3)
    );

    typedef struct {
        logic [1:0]  empty;
        logic [1:0]  on;
        flit_label_t l0;
        flit_label_t l1;
        logic        stall;
        logic [1:0]  rd;
        logic        sel;
        logic        vld;
        logic [1:0]  act;
        logic        err;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act_v, exp_v, $time);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] rd, input logic sel,
                        input logic vld, input logic [1:0] act_e, input logic err_e);
        chk({tag, " read_o"}, 32'(read), 32'(rd));
        chk({tag, " vc_sel_o"}, 32'(vc_sel), 32'(sel));
        chk({tag, " valid_o"}, 32'(valid), 32'(vld));
        chk({tag, " packet_active_o"}, 32'(active), 32'(act_e));
        chk({tag, " protocol_err_o"}, 32'(err), 32'(err_e));
    endtask

    task automatic chk3(input string tag, input logic [2:0] rd, input logic [1:0] sel,
                        input logic vld, input logic err_e);
        chk({tag, " read3"}, 32'(read3), 32'(rd));
        chk({tag, " vc_sel3"}, 32'(vc_sel3), 32'(sel));
        chk({tag, " valid3"}, 32'(valid3), 32'(vld));
        chk({tag, " err3"}, 32'(err3), 32'(err_e));
    endtask

    initial begin
        //           empty  on     l0        l1        stl   rd     sel   vld   act    err
        vecs[0]  = '{2'b00, 2'b11, HEADTAIL, HEADTAIL, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0};
        vecs[1]  = '{2'b00, 2'b11, HEADTAIL, HEADTAIL, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 1'b0};
        vecs[2]  = '{2'b00, 2'b11, HEADTAIL, HEADTAIL, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0};
        vecs[3]  = '{2'b00, 2'b11, HEADTAIL, HEADTAIL, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 1'b0};
        vecs[4]  = '{2'b00, 2'b11, HEAD,     HEADTAIL, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0};
        vecs[5]  = '{2'b00, 2'b11, BODY,     HEADTAIL, 1'b0, 2'b10, 1'b1, 1'b1, 2'b01, 1'b0};
        vecs[6]  = '{2'b00, 2'b11, BODY,     HEADTAIL, 1'b0, 2'b01, 1'b0, 1'b1, 2'b01, 1'b0};
        vecs[7]  = '{2'b00, 2'b11, TAIL,     HEADTAIL, 1'b0, 2'b10, 1'b1, 1'b1, 2'b01, 1'b0};
        vecs[8]  = '{2'b00, 2'b11, TAIL,     HEADTAIL, 1'b0, 2'b01, 1'b0, 1'b1, 2'b01, 1'b0};
        vecs[9]  = '{2'b00, 2'b11, HEADTAIL, HEADTAIL, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0};
        vecs[10] = '{2'b00, 2'b11, HEADTAIL, HEADTAIL, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0};
        vecs[11] = '{2'b00, 2'b11, HEADTAIL, HEADTAIL, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 1'b0};
        vecs[12] = '{2'b00, 2'b10, HEADTAIL, HEADTAIL, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 1'b0};
        vecs[13] = '{2'b00, 2'b10, HEADTAIL, HEADTAIL, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 1'b0};
        vecs[14] = '{2'b11, 2'b11, HEADTAIL, HEADTAIL, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0};
        vecs[15] = '{2'b00, 2'b11, BODY,     HEADTAIL, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0};
        vecs[16] = '{2'b00, 2'b11, HEADTAIL, HEADTAIL, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 1'b1};
        vecs[17] = '{2'b00, 2'b11, HEADTAIL, HEADTAIL, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 1'b1};

        rst = 1'b0;
        is_empty = 2'b00; on_off = 2'b11; stall = 1'b0;
        lab[0] = HEADTAIL; lab[1] = HEADTAIL;
        is_empty3 = 3'b111; on_off3 = 3'b111; stall3 = 1'b0;
        lab3[0] = HEADTAIL; lab3[1] = HEADTAIL; lab3[2] = HEADTAIL;

        #12;
        chk2("reset", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            is_empty = vecs[i].empty;
            on_off   = vecs[i].on;
            lab[0]   = vecs[i].l0;
            lab[1]   = vecs[i].l1;
            stall    = vecs[i].stall;
            #1;
            chk2($sformatf("vec%0d", i), vecs[i].rd, vecs[i].sel, vecs[i].vld,
                 vecs[i].act, vecs[i].err);
            @(negedge clk);
        end

        // VC0 opens a packet, goes empty mid-packet and is skipped, then resumes.
        is_empty = 2'b00; on_off = 2'b01; lab[0] = HEAD; lab[1] = HEADTAIL;
        #1 chk2("open_vc0", 2'b01, 1'b0, 1'b1, 2'b00, 1'b1);
        @(negedge clk);
        is_empty = 2'b01; on_off = 2'b11;
        #1 chk2("skip_empty_vc0", 2'b10, 1'b1, 1'b1, 2'b01, 1'b1);
        @(negedge clk);
        is_empty = 2'b00; on_off = 2'b01; lab[0] = BODY;
        #1 chk2("resume_vc0", 2'b01, 1'b0, 1'b1, 2'b01, 1'b1);
        @(negedge clk);

        // Async reset mid-packet with rr_ptr at 1.
        on_off = 2'b11; lab[0] = HEADTAIL;
        #1 chk("pre_reset active", 32'(active), 32'(2'b01));
        #1 rst = 1'b0;
        #1 chk2("async_reset", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk2("post_reset", 2'b01, 1'b0, 1'b1, 2'b00, 1'b0);
        @(negedge clk);

        // Three VCs: sole eligible VC2 bursts, then rr_ptr must have wrapped to 0.
        is_empty3 = 3'b011;
        for (int i = 0; i < 3; i++) begin
            #1 chk3($sformatf("vc2_burst%0d", i), 3'b100, 2'd2, 1'b1, 1'b0);
            @(negedge clk);
        end
        is_empty3 = 3'b000;
        #1 chk3("wrap_to_0", 3'b001, 2'd0, 1'b1, 1'b0);
        @(negedge clk);
        #1 chk3("next_1", 3'b010, 2'd1, 1'b1, 1'b0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vc_read_scheduler.md
Name: vc_read_scheduler

Overview:
Per-input-port scheduler that shares the single switch-traversal read slot among the VC_NUM circular buffers of one router input port. Each cycle it picks one non-empty VC whose downstream on/off flag allows transmission, using flit-level round-robin. It drives that buffer's read strobe and tracks per-VC packet state (head..tail) from the flit labels. It sits between the per-VC circular_buffer instances and the crossbar/switch-allocation stage.

Parameters:
VC_NUM, 2, number of virtual channels (circular buffers) scheduled; legal range 2..8
VC_SIZE, $clog2(VC_NUM), width of the VC index; localparam, not overridable

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous, active-low reset
is_empty_i  input  VC_NUM  per-VC buffer empty flag (circular_buffer is_empty_o)
on_off_i  input  VC_NUM  per-VC downstream on/off flag, 1 = may send
flit_label_i  input  VC_NUM x flit_label_t  label of the head-of-queue flit of each VC buffer (HEAD, BODY, TAIL, HEADTAIL)
stall_i  input  1  crossbar not ready this cycle; suppresses any grant
read_o  output  VC_NUM  one-hot read strobe to the circular buffers (read_i)
valid_o  output  1  a flit is read this cycle
vc_sel_o  output  VC_SIZE  index of the granted VC; 0 when valid_o=0
packet_active_o  output  VC_NUM  per-VC packet-in-progress state (1 = ACTIVE)
protocol_err_o  output  1  sticky label-sequence error flag

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-packet): rr_ptr=0, all VC states IDLE, protocol_err_o=0. Outputs take their reset values immediately: packet_active_o=0. read_o, valid_o and vc_sel_o are 0 as long as eligibility is 0 or rst=0. Grant is forced off while rst=0.
- Eligibility: elig[v] = ~is_empty_i[v] & on_off_i[v] & ~stall_i.
- Grant is combinational, same cycle as eligibility, zero latency:
  - Scan v = rr_ptr, rr_ptr+1, ... modulo VC_NUM.
  - The first eligible v gets read_o[v]=1, valid_o=1, vc_sel_o=v.
  - At most one read_o bit is ever set.
  - If no VC is eligible, read_o=0, valid_o=0, vc_sel_o=0.
- rr_ptr register, updated at posedge:
  - On a grant to v: rr_ptr <= (v+1) mod VC_NUM. Wrap is required at v=VC_NUM-1, and must also hold for non-power-of-2 VC_NUM.
  - No grant: rr_ptr unchanged.
- Per-VC FSM, updated only for the granted VC, at posedge, using flit_label_i[v]:
  - IDLE + HEAD -> ACTIVE
  - IDLE + HEADTAIL -> IDLE
  - IDLE + BODY or TAIL -> IDLE, set protocol_err_o
  - ACTIVE + BODY -> ACTIVE
  - ACTIVE + TAIL -> IDLE
  - ACTIVE + HEAD -> ACTIVE, set protocol_err_o
  - ACTIVE + HEADTAIL -> IDLE, set protocol_err_o
  - Non-granted VCs hold their state.
- packet_active_o[v] is 1 exactly when VC v is ACTIVE.
- protocol_err_o is sticky until reset. Errors do not block scheduling.
- Arbitration is per flit, not per packet: packets on different VCs interleave flit by flit.
- Boundary conditions:
  - A VC whose buffer goes empty or whose on_off_i drops mid-packet stays ACTIVE and is simply skipped.
  - Bursts of the same VC occur only when it is the sole eligible VC. Back-to-back reads from one VC on consecutive cycles are allowed; the buffer's is_empty_o must reflect the previous read by the next cycle.
  - stall_i=1 freezes rr_ptr and all FSMs.
  - flit_label_i of a non-granted or empty VC is ignored.

Test Plan:
- Reset with all VCs eligible (VC_NUM=2): after rst deasserts, cycle 1 gives read_o=01, vc_sel_o=0; cycle 2 gives read_o=10, vc_sel_o=1; grants keep alternating 0,1,0,1.
- VC_NUM=3, only VC2 eligible for 3 cycles, all labels HEADTAIL -> read_o=100 on each cycle, rr_ptr wraps to 0, protocol_err_o=0.
- VC0 streams HEAD,BODY,TAIL while VC1 streams HEADTAIL: grants interleave 0,1,0,1,0; packet_active_o[0]=1 from after the HEAD read until after the TAIL read; packet_active_o[1] stays 0.
- on_off_i=10 with both VCs non-empty -> only VC1 is granted; stall_i=1 for 2 cycles -> valid_o=0 and rr_ptr is held.
- Granted label BODY on an IDLE VC0 -> protocol_err_o=1 from the next cycle, remains 1 across later legal packets, and clears only on rst=0.
- Assert rst=0 asynchronously mid-packet with VC0 ACTIVE -> packet_active_o=00 immediately, protocol_err_o=0; the next grant after release starts from VC0.
